// File: rtl/imuldiv_muldiv_issue_if.sv
// Purpose: bundles the command, muldiv request/response and writeback handshakes of the issue block.
// Latency: none; signal container only.
// Backpressure: carries val/rdy pairs for each channel; the issue block uses the slave side.
interface imuldiv_muldiv_issue_if;
  // execute-stage command
  logic        cmd_val;
  logic        cmd_rdy;
  logic [2:0]  cmd_fn;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [4:0]  cmd_dst;
  // request toward the muldiv unit
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  // response from the muldiv unit
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  // registered writeback
  logic        wb_val;
  logic        wb_rdy;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [3:0]  inflight;

  // environment side: issue logic, muldiv unit and writeback consumer
  modport master (
    output cmd_val, cmd_fn, cmd_a, cmd_b, cmd_dst,
    output muldivreq_rdy, muldivresp_msg_result, muldivresp_val, wb_rdy,
    input  cmd_rdy, muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
    input  muldivresp_rdy, wb_val, wb_dst, wb_data, inflight
  );

  // issue block side
  modport slave (
    input  cmd_val, cmd_fn, cmd_a, cmd_b, cmd_dst,
    input  muldivreq_rdy, muldivresp_msg_result, muldivresp_val, wb_rdy,
    output cmd_rdy, muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
    output muldivresp_rdy, wb_val, wb_dst, wb_data, inflight
  );
endinterface

// File: rtl/imuldiv_muldiv_issue.sv
// Purpose: issues mul/div/rem commands to the muldiv unit and pairs in-order responses with their dst tags.
// Latency: command->request 0 cycles (pass-through); response->writeback 1 cycle (registered).
// Backpressure: commands stall when DEPTH tags are in flight; responses stall while writeback is held.
module imuldiv_muldiv_issue #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  imuldiv_muldiv_issue_if.slave io
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [3:0]       count;
  logic [DEPTH-1:0] tag_sel_hi;
  logic [4:0]       tag_dst [DEPTH];

  logic        wb_val_r;
  logic [4:0]  wb_dst_r;
  logic [31:0] wb_data_r;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic cmd_sel_hi;
  logic resp_rdy;

  // Full/empty come only from the registered count so no combinational path runs response -> command.
  assign full       = (count == 4'(DEPTH));
  assign empty      = (count == 4'd0);
  // rem/remu write back the remainder half; everything else (including unused codes 5..7) takes the low word.
  assign cmd_sel_hi = (io.cmd_fn == 3'd3) || (io.cmd_fn == 3'd4);
  assign resp_rdy   = !empty && (!wb_val_r || io.wb_rdy);
  assign push       = io.cmd_val && io.cmd_rdy;
  assign pop        = io.muldivresp_val && resp_rdy;

  assign io.muldivreq_msg_fn = io.cmd_fn;
  assign io.muldivreq_msg_a  = io.cmd_a;
  assign io.muldivreq_msg_b  = io.cmd_b;
  assign io.muldivreq_val    = io.cmd_val && !full;
  assign io.cmd_rdy          = io.muldivreq_rdy && !full;
  assign io.muldivresp_rdy   = resp_rdy;
  assign io.wb_val           = wb_val_r;
  assign io.wb_dst           = wb_dst_r;
  assign io.wb_data          = wb_data_r;
  assign io.inflight         = count;

  // Tag FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 4'd0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + {3'd0, push} - {3'd0, pop};
    end
  end

  // Tag storage: {sel_hi, dst} written at the tail on each accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_sel_hi <= '0;
      for (int i = 0; i < DEPTH; i++) tag_dst[i] <= 5'd0;
    end else if (push) begin
      tag_sel_hi[tail] <= cmd_sel_hi;
      tag_dst[tail]    <= io.cmd_dst;
    end
  end

  // Writeback register: a pop reloads it even while the previous word drains, giving bubble-free writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_val_r  <= 1'b0;
      wb_dst_r  <= 5'd0;
      wb_data_r <= 32'd0;
    end else if (pop) begin
      wb_val_r  <= 1'b1;
      wb_dst_r  <= tag_dst[head];
      wb_data_r <= tag_sel_hi[head] ? io.muldivresp_msg_result[63:32]
                                    : io.muldivresp_msg_result[31:0];
    end else if (wb_val_r && io.wb_rdy) begin
      wb_val_r <= 1'b0;
    end
  end

endmodule
